// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-producer handshake and common data bus bundle for cdb_arbiter
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int TAG_BITS = 4,
  parameter int DATA_W   = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);
  logic                         flush;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*TAG_BITS-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0]    req_value;
  logic                         cdb_valid;
  logic [TAG_BITS-1:0]          cdb_tag;
  logic [DATA_W-1:0]            cdb_value;
  logic [SRC_W-1:0]             cdb_src;
  logic                         busy;
  modport master (
    output flush, req_valid, req_tag, req_value,
    input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, busy
  );
  modport slave (
    input  flush, req_valid, req_tag, req_value,
    output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of one registered common data bus among NUM_REQ result producers.
// Each producer owns a one-entry holding register; a flush drops everything in flight.
// Define CDB_ARB_BYPASS_EN to let an empty-hold producer compete directly with its incoming result.
module cdb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int TAG_BITS = 4,
  parameter int DATA_W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  r_hold_valid;
  logic [TAG_BITS-1:0] r_hold_tag   [NUM_REQ];
  logic [DATA_W-1:0]   r_hold_value [NUM_REQ];
  logic [SW-1:0]       r_rr_ptr;
  logic                r_cdb_valid;
  logic [TAG_BITS-1:0] r_cdb_tag;
  logic [DATA_W-1:0]   r_cdb_value;
  logic [SW-1:0]       r_cdb_src;

  logic [NUM_REQ-1:0]  w_cand;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_byp;
  logic [NUM_REQ-1:0]  w_ready;
  logic [NUM_REQ-1:0]  w_load;
  logic                w_any;
  logic [SW-1:0]       w_win;
  logic [TAG_BITS-1:0] w_win_tag;
  logic [DATA_W-1:0]   w_win_value;

`ifdef CDB_ARB_BYPASS_EN
  assign w_cand = r_hold_valid | bus.req_valid;
`else
  assign w_cand = r_hold_valid;
`endif

  // Round-robin pick: first scan from rr_ptr upward, then wrap to the low indices.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_any && w_cand[i] && SW'(i) >= r_rr_ptr) begin
        w_any      = 1'b1;
        w_grant[i] = 1'b1;
        w_win      = SW'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_any && w_cand[i]) begin
        w_any      = 1'b1;
        w_grant[i] = 1'b1;
        w_win      = SW'(i);
      end
  end

  // A granted requester with an empty hold is a bypass winner: its input goes straight to the bus.
  assign w_byp       = w_grant & ~r_hold_valid;
  assign w_ready     = ~r_hold_valid | w_grant;
  assign w_load      = bus.req_valid & w_ready & ~w_byp;
  assign w_win_tag   = r_hold_valid[w_win] ? r_hold_tag[w_win]
                                           : bus.req_tag[int'(w_win)*TAG_BITS +: TAG_BITS];
  assign w_win_value = r_hold_valid[w_win] ? r_hold_value[w_win]
                                           : bus.req_value[int'(w_win)*DATA_W +: DATA_W];

  // Holding registers: a reload on the drain edge wins over the clear, keeping one result/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold_tag[i]   <= '0;
        r_hold_value[i] <= '0;
      end
    end else if (bus.flush) begin
      r_hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_load[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_tag[i]   <= bus.req_tag[i*TAG_BITS +: TAG_BITS];
          r_hold_value[i] <= bus.req_value[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
    end
  end

  // Registered broadcast and round-robin pointer; payload holds its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (bus.flush) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_tag   <= w_win_tag;
        r_cdb_value <= w_win_value;
        r_cdb_src   <= w_win;
        r_rr_ptr    <= (w_win == SW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_value = r_cdb_value;
  assign bus.cdb_src   = r_cdb_src;
  assign bus.busy      = |r_hold_valid | r_cdb_valid;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (per-requester expected queues plus broadcast log)
module tb_cdb_arbiter;
  localparam int N = 3;
`ifdef CDB_ARB_BYPASS_EN
  localparam int LAT = 0;
  localparam logic [2:0] RDY0 = 3'b111;
`else
  localparam int LAT = 1;
  localparam logic [2:0] RDY0 = 3'b101;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] src;
    logic [3:0] tag;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [35:0] sbq [N][$];
  obs_t obs [$];

  cdb_arbiter_if #(.NUM_REQ(N), .TAG_BITS(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .TAG_BITS(4), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic obs_t ob(input int k);
    obs_t o;
    o.cyc = -1000;
    o.src = 2'b11;
    o.tag = 'x;
    if (k < obs.size()) o = obs[k];
    return o;
  endfunction

  task automatic put(input int i, input logic [3:0] t, input logic [31:0] v);
    bus.req_valid[i] = 1'b1;
    bus.req_tag[i*4 +: 4] = t;
    bus.req_value[i*32 +: 32] = v;
    sbq[i].push_back({t, v});
  endtask

  task automatic idle();
    bus.req_valid = '0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Broadcast monitor: every cdb_valid cycle must match the oldest pending result of that source.
  always @(negedge clk) begin
    if (rst_n && bus.cdb_valid) begin
      int   n;
      obs_t o;
      o.cyc = cyc;
      o.src = bus.cdb_src;
      o.tag = bus.cdb_tag;
      obs.push_back(o);
      n = (bus.cdb_src < 2'd3) ? sbq[bus.cdb_src].size() : 0;
      if (n > 0) chk("sb_data", {bus.cdb_tag, bus.cdb_value}, sbq[bus.cdb_src].pop_front());
      else chk("sb_pending", n, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         a_cyc, acc2_cyc, seen2, sent0, n2;
    logic [2:0] acc, pat;
    logic [3:0] t0;
    bus.flush = 1'b0;
    bus.req_valid = '0;
    bus.req_tag = '0;
    bus.req_value = '0;
    #12;
    chk("rst_cdb_valid", bus.cdb_valid, 0);
    chk("rst_cdb_tag", bus.cdb_tag, 0);
    chk("rst_cdb_value", bus.cdb_value, 0);
    chk("rst_cdb_src", bus.cdb_src, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;

    // single request latency and one-cycle broadcast
    obs.delete();
    drive_edge();
    put(0, 4'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready", bus.req_ready, 3'b111);
    drive_edge();
    a_cyc = cyc;
    idle();
    repeat (4) @(negedge clk);
    chk("t1_count", obs.size(), 1);
    chk("t1_src", ob(0).src, 0);
    chk("t1_tag", ob(0).tag, 5);
    chk("t1_latency", ob(0).cyc - a_cyc, LAT);
    chk("t1_busy", bus.busy, 0);

    // three held results drain in round-robin order from rr_ptr=0
    drive_edge();
    bus.flush = 1'b1;
    drive_edge();
    bus.flush = 1'b0;
    obs.delete();
    put(0, 4'd1, 32'h11);
    put(1, 4'd2, 32'h22);
    put(2, 4'd3, 32'h33);
    drive_edge();
    idle();
    repeat (5) @(negedge clk);
    chk("rr3_count", obs.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("rr3_src", ob(k).src, k);
      chk("rr3_consecutive", ob(k).cyc - ob(0).cyc, k);
    end
    chk("rr3_busy", bus.busy, 0);
    obs.delete();
    drive_edge();
    put(0, 4'd10, 32'hA0);
    put(2, 4'd11, 32'hB0);
    drive_edge();
    idle();
    repeat (4) @(negedge clk);
    chk("rr3_wrap_first", ob(0).src, 0);
    chk("rr3_wrap_second", ob(1).src, 2);

    // requester 0 streams while requester 2 holds tag 7
    obs.delete();
    drive_edge();
    t0 = 4'd8;
    sent0 = 0;
    acc2_cyc = 0;
    seen2 = 1000000;
    pat = '0;
    bus.req_valid = 3'b101;
    bus.req_tag[3:0] = t0;
    bus.req_value[31:0] = {28'h5000000, t0};
    bus.req_tag[11:8] = 4'd7;
    bus.req_value[95:64] = 32'h77;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (c >= 1 && c <= 3) pat[c-1] = bus.req_ready[0];
      drive_edge();
      if (acc[0]) begin
        sbq[0].push_back({t0, 28'h5000000, t0});
        sent0++;
        t0++;
        bus.req_tag[3:0] = t0;
        bus.req_value[31:0] = {28'h5000000, t0};
        if (sent0 == 6) bus.req_valid[0] = 1'b0;
      end
      if (acc[2]) begin
        sbq[2].push_back({4'd7, 32'h77});
        acc2_cyc = cyc;
        bus.req_valid[2] = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    for (int k = 0; k < obs.size(); k++)
      if (obs[k].src == 2'd2) seen2 = obs[k].cyc;
    chk("st_sent0", sent0, 6);
    chk("st_ready0_pattern", pat, RDY0);
    chk("st_tag7_bound", (seen2 - acc2_cyc) <= N, 1);
    chk("st_busy", bus.busy, 0);

    // flush with holds 011 valid and requester 2 presenting
    obs.delete();
    drive_edge();
    put(0, 4'd1, 32'hF1);
    put(1, 4'd2, 32'hF2);
    drive_edge();
    bus.flush = 1'b1;
    bus.req_valid = 3'b100;
    bus.req_tag[11:8] = 4'd12;
    bus.req_value[95:64] = 32'hCC;
    @(negedge clk);
    chk("fl_ready2", bus.req_ready[2], 1);
    drive_edge();
    bus.flush = 1'b0;
    idle();
    sbq[0].delete();
    sbq[1].delete();
    @(negedge clk);
    chk("fl_cdb_valid", bus.cdb_valid, 0);
    chk("fl_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    n2 = 0;
    for (int k = 0; k < obs.size(); k++)
      if (obs[k].src == 2'd2) n2++;
    chk("fl_no_req2", n2, 0);
    chk("fl_count", obs.size(), LAT == 0 ? 1 : 0);
    obs.delete();
    drive_edge();
    put(0, 4'd13, 32'hD0);
    put(2, 4'd14, 32'hE0);
    drive_edge();
    idle();
    repeat (4) @(negedge clk);
    chk("fl_rr_first", ob(0).src, 0);
    chk("fl_rr_second", ob(1).src, 2);

    // async reset mid-cycle while broadcasting, with a result still held
    obs.delete();
    drive_edge();
    put(0, 4'd6, 32'h66);
    put(1, 4'd8, 32'h88);
    drive_edge();
    idle();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("ar_cdb_valid_before", bus.cdb_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cdb_valid", bus.cdb_valid, 0);
    chk("ar_ready", bus.req_ready, 3'b111);
    chk("ar_busy", bus.busy, 0);
    sbq[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_count", obs.size(), 1);

    // same requester back-to-back keeps order on consecutive cycles
    obs.delete();
    drive_edge();
    put(1, 4'd4, 32'h44);
    drive_edge();
    put(1, 4'd9, 32'h99);
    @(negedge clk);
    chk("b2b_ready", bus.req_ready[1], 1);
    drive_edge();
    idle();
    repeat (4) @(negedge clk);
    chk("b2b_count", obs.size(), 2);
    chk("b2b_first", ob(0).tag, 4);
    chk("b2b_second", ob(1).tag, 9);
    chk("b2b_src", ob(1).src, 1);
    chk("b2b_gap", ob(1).cyc - ob(0).cyc, 1);

    for (int i = 0; i < N; i++) chk("sb_drained", sbq[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional-unit result producers, e.g. ALU reservation-station executor, load/store unit and branch unit.
- Each requester hands its result (ROB tag + value) into a one-entry holding register.
- A round-robin arbiter picks one held result per cycle and drives it onto a registered CDB. Reservation stations and the ROB snoop that CDB.
- Branch-mispredict flush discards all in-flight results.

Parameters:
- NUM_REQ, 3, number of result producers (2..8)
- TAG_BITS, 4, ROB tag width (matches ROB depth bits)
- DATA_W, 32, result value width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch-mispredict flush, synchronous
- req_valid  in  NUM_REQ  requester i presents a result
- req_ready  out  NUM_REQ  requester i result accepted this cycle
- req_tag  in  NUM_REQ*TAG_BITS  packed ROB tags, slice i at [i*TAG_BITS +: TAG_BITS]
- req_value  in  NUM_REQ*DATA_W  packed result values
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_BITS  broadcast ROB tag
- cdb_value  out  DATA_W  broadcast value
- cdb_src  out  $clog2(NUM_REQ)  index of the winning requester
- busy  out  1  any holding entry or CDB register valid

Behaviour:
- State:
  - hold_valid/hold_tag/hold_value per requester.
  - rr_ptr ($clog2(NUM_REQ) bits).
  - Registered CDB outputs.
- Reset (async, rst_n=0):
  - hold_valid=0 and rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
  - busy=0 and req_ready=all ones (combinational on empty holds).
- Accept: req_ready[i] = !hold_valid[i] | grant[i]. On the edge with req_valid[i]&req_ready[i], the hold entry is loaded with tag/value and hold_valid[i] is set.
- Arbitration (combinational):
  - Candidates are hold_valid[i].
  - Search starts at rr_ptr, ascending with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). The first candidate wins; grant is one-hot or zero.
- Broadcast:
  - On an edge with a grant, the CDB registers take the winner's tag, value and index, and cdb_valid=1.
  - The winner's hold_valid clears unless it is reloaded in the same edge.
  - rr_ptr becomes winner+1, wrapping NUM_REQ-1 to 0.
  - With no grant, cdb_valid=0, cdb_tag/value/src hold their last values, and rr_ptr is unchanged.
- Latency: result accepted at edge E0 → earliest cdb_valid after edge E1, lasting exactly one cycle per result. Throughput is one result/cycle total.
- Simultaneous drain + new request on the same requester: the new result is accepted, so that requester sustains one result/cycle when uncontested.
- Starvation bound: a held result is broadcast within NUM_REQ cycles.
- Flush (sync, highest priority):
  - On an edge with flush=1, all hold_valid clear and cdb_valid=0 next cycle; rr_ptr resets to 0.
  - Requests presented that cycle are dropped, even though req_ready may be high.
  - No grant takes effect on a flush edge.
- Reset mid-operation: all state clears immediately regardless of clk; no partial broadcast.
- busy = |hold_valid | cdb_valid.
- Tag/value are passed through unmodified. No ordering guarantee across requesters; same-requester order is preserved.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- When defined:
  - A requester whose hold is empty also competes with its incoming req_valid in the same cycle.
  - The candidate is hold_valid[i] | (req_valid[i] & !hold_valid[i]).
  - If it wins, the result goes straight to the CDB registers, bypassing hold, so the best-case latency is one edge.
  - If it loses, it is captured in hold as normal.
  - Flush still drops it.
- When undefined: candidates are hold entries only, with two-edge minimum latency as above.

Test Plan:
- Reset then single request: req_valid=001, tag=5, value=0xDEADBEEF at E0 → cdb_valid=1, cdb_tag=5, cdb_value=0xDEADBEEF, cdb_src=0 after E1 (after E0 with CDB_ARB_BYPASS_EN); cdb_valid=0 the next cycle.
- All three requesters hold results (tags 1,2,3), rr_ptr=0 → broadcasts in order src 0,1,2 on three consecutive cycles; then rr_ptr=0, busy=0.
- Requester 0 streams a result every cycle while requester 2 holds tag 7 → tag 7 is broadcast within 3 cycles and requester 0 is never deadlocked; req_ready[0] toggles per grant.
- Flush while holds 011 are valid and req_valid[2]=1 → next cycle cdb_valid=0, busy=0, rr_ptr=0, and no tag from requester 2 ever appears.
- Async reset asserted mid-cycle with cdb_valid=1 → cdb_valid drops to 0 before the next clk edge, and req_ready=111.
- Same-requester back-to-back: requester 1 issues tags 4 then 9 on consecutive cycles with no contention → CDB shows 4 then 9 on consecutive cycles, with no reordering.
